// File: rtl/fetch_ctrl.sv
// Purpose: instruction fetch sequencer between the PC register and an Avalon-MM instruction port.
// Latency: one FETCH cycle plus one EXEC cycle per instruction when the bus and datapath never stall.
// Backpressure: waitrequest holds FETCH with the request stable; stall holds EXEC and withholds pc_en.
module fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pc_en,
  output logic [31:0] address,
  output logic        read,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        stall,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        active
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   capture;
  logic   at_halt;

  // The PC register owns the reset vector; a misaligned value could never be fetched
  // as a whole word, so reject it when the design is elaborated.
  if (RESET_VECTOR[1:0] != 2'b00) begin : g_bad_reset_vector
    $error("fetch_ctrl: RESET_VECTOR must be word aligned");
  end

  // Exact 32-bit match; no masking of low bits.
  assign at_halt = (pc == HALT_ADDR);

  // State register; reset drops straight to IDLE from any state, HALT included.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Instruction latch: loaded only on the edge that completes a read, cleared by reset
  // so a response that arrives while in reset is never taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr <= 32'h0;
    end else if (capture) begin
      instr <= readdata;
    end
  end

  // Next-state and outputs; all outputs decode from state so reset silences them at once.
  always_comb begin
    state_nxt   = state;
    read        = 1'b0;
    address     = 32'h0;
    byteenable  = 4'h0;
    pc_en       = 1'b0;
    instr_valid = 1'b0;
    active      = 1'b0;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = FETCH;
      end
      FETCH: begin
        active = 1'b1;
        if (at_halt) begin
          state_nxt = HALT;
        end else begin
          // Request stays asserted and stable for as long as the slave stalls.
          read       = 1'b1;
          address    = pc;
          byteenable = 4'hF;
          if (!waitrequest) begin
            capture   = 1'b1;
            state_nxt = EXEC;
          end
        end
      end
      EXEC: begin
        active      = 1'b1;
        instr_valid = 1'b1;
        // The PC advances on the single cycle the datapath accepts the instruction.
        if (!stall) begin
          pc_en     = 1'b1;
          state_nxt = FETCH;
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Purpose: randomized and directed checking of fetch_ctrl against an instruction-level model.
// Latency: model predicts outputs of every sampled cycle; PC register is emulated by the bench.
// Backpressure: random waitrequest/stall stress both hold conditions.
module tb_fetch_ctrl;

  localparam logic [31:0] RV = 32'hBFC00000;
  localparam logic [31:0] HA = 32'h00000000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc = RV;
  logic        pc_en;
  logic [31:0] address;
  logic        read;
  logic [3:0]  byteenable;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = 32'h0;
  logic        stall = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        active;

  fetch_ctrl #(.RESET_VECTOR(RV), .HALT_ADDR(HA)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_en(pc_en), .address(address), .read(read),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata), .stall(stall),
    .instr(instr), .instr_valid(instr_valid), .active(active)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int pcen_count = 0;

  // Instruction-level model: has the CPU started, stopped for good, or is it holding
  // a fetched instruction that the datapath has not yet retired.
  bit          m_started = 1'b0;
  bit          m_halted  = 1'b0;
  bit          m_holding = 1'b0;
  logic [31:0] m_instr   = 32'h0;
  logic [31:0] pc_reg    = RV;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sample at the falling edge, compare against the model, then advance the model and PC.
  task automatic eval_cycle();
    logic        e_read, e_pcen, e_valid, e_active;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    @(negedge clk);
    e_read = 1'b0; e_pcen = 1'b0; e_valid = 1'b0; e_active = 1'b0;
    e_addr = 32'h0; e_be = 4'h0;
    if (m_started && !m_halted) begin
      e_active = 1'b1;
      if (m_holding) begin
        e_valid = 1'b1;
        e_pcen  = !stall;
      end else if (pc != HA) begin
        e_read = 1'b1;
        e_addr = pc;
        e_be   = 4'hF;
      end
    end
    chk("read", {31'h0, read}, {31'h0, e_read});
    chk("address", address, e_addr);
    chk("byteenable", {28'h0, byteenable}, {28'h0, e_be});
    chk("pc_en", {31'h0, pc_en}, {31'h0, e_pcen});
    chk("instr_valid", {31'h0, instr_valid}, {31'h0, e_valid});
    chk("active", {31'h0, active}, {31'h0, e_active});
    chk("instr", instr, m_instr);
    chk("inv_read_be", {28'h0, (read ? byteenable : 4'hF)}, 32'hF);
    chk("inv_pcen_valid", {31'h0, (pc_en ? instr_valid : 1'b1)}, 32'h1);
    chk("inv_read_pcen", {31'h0, (read & pc_en)}, 32'h0);
    if (pc_en) pcen_count++;
    if (!m_started) begin
      m_started = 1'b1;
    end else if (!m_halted) begin
      if (m_holding) begin
        if (!stall) m_holding = 1'b0;
      end else if (pc == HA) begin
        m_halted = 1'b1;
      end else if (!waitrequest) begin
        m_holding = 1'b1;
        m_instr   = readdata;
      end
    end
    if (e_pcen) pc_reg = pc_reg + 32'd4;
  endtask

  task automatic run_cycle(input logic w, input logic s, input logic [31:0] rd);
    @(posedge clk);
    #1;
    waitrequest = w; stall = s; readdata = rd; pc = pc_reg;
    eval_cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_read"}, {31'h0, read}, 32'h0);
    chk({tag, "_pc_en"}, {31'h0, pc_en}, 32'h0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_valid"}, {31'h0, instr_valid}, 32'h0);
    chk({tag, "_active"}, {31'h0, active}, 32'h0);
    chk({tag, "_address"}, address, 32'h0);
    chk({tag, "_be"}, {28'h0, byteenable}, 32'h0);
  endtask

  task automatic model_reset();
    m_started = 1'b0; m_halted = 1'b0; m_holding = 1'b0; m_instr = 32'h0;
  endtask

  // Release away from the edge; the first sampled cycle afterwards is the IDLE cycle.
  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    pc_reg = RV; pc = RV; waitrequest = 1'b0; stall = 1'b0; readdata = $urandom;
    eval_cycle();
  endtask

  task automatic to_fetch();
    int n;
    n = 0;
    while (!(m_started && !m_halted && !m_holding) && n < 20) begin
      run_cycle(1'b0, 1'b0, $urandom);
      n++;
    end
    if (n >= 20) chk("to_fetch_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    // Power-on reset
    #1;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    release_reset();

    // Back-to-back fetches at full rate from the reset vector
    pcen_count = 0;
    run_cycle(1'b0, 1'b0, $urandom);
    chk("first_read", {31'h0, read}, 32'h1);
    chk("first_addr", address, RV);
    for (int i = 1; i < 200; i++) run_cycle(1'b0, 1'b0, $urandom);
    chk("pcen_pulses_100", pcen_count, 32'd100);

    // Slave stalls three cycles, then returns a known word
    to_fetch();
    begin
      logic [31:0] a0;
      a0 = pc_reg;
      for (int i = 0; i < 3; i++) begin
        run_cycle(1'b1, 1'b1, $urandom);
        chk("wait_addr", address, a0);
        chk("wait_read", {31'h0, read}, 32'h1);
      end
      run_cycle(1'b0, 1'b1, 32'h2402000A);
      chk("wait_addr_last", address, a0);
    end
    // Datapath stall: this is the first of five stalled EXEC cycles
    run_cycle(1'b0, 1'b1, $urandom);
    chk("exec_instr", instr, 32'h2402000A);
    chk("exec_valid", {31'h0, instr_valid}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b0, 1'b1, $urandom);
      chk("stall_pc_en", {31'h0, pc_en}, 32'h0);
      chk("stall_instr", instr, 32'h2402000A);
    end
    run_cycle(1'b0, 1'b0, $urandom);
    chk("stall_release_pc_en", {31'h0, pc_en}, 32'h1);

    // Random backpressure on both sides
    for (int i = 0; i < 1500; i++)
      run_cycle(($urandom % 3) == 0, ($urandom % 4) == 0, $urandom);

    // Reset asserted mid-fetch while the slave is stalling
    to_fetch();
    @(posedge clk);
    #1;
    waitrequest = 1'b1; stall = 1'b0; pc = pc_reg;
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midfetch");
    model_reset();
    waitrequest = 1'b0; readdata = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1;
    chk("midfetch_no_capture", instr, 32'h0);
    release_reset();
    for (int i = 0; i < 60; i++)
      run_cycle(($urandom % 3) == 0, ($urandom % 4) == 0, $urandom);

    // Walk the PC up to the halt address; neighbours must not halt
    to_fetch();
    pc_reg = 32'hFFFFFFF8;
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b0, $urandom);
    chk("halt_pc", pc, HA);
    chk("halt_active", {31'h0, active}, 32'h0);
    for (int i = 0; i < 50; i++) begin
      run_cycle($urandom_range(0, 1), $urandom_range(0, 1), $urandom);
      chk("halted_active", {31'h0, active}, 32'h0);
      chk("halted_read", {31'h0, read}, 32'h0);
    end

    // Only reset leaves HALT
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("halt_rst");
    model_reset();
    release_reset();
    run_cycle(1'b0, 1'b0, $urandom);
    chk("restart_read", {31'h0, read}, 32'h1);
    chk("restart_addr", address, RV);
    for (int i = 0; i < 40; i++)
      run_cycle(($urandom % 3) == 0, ($urandom % 4) == 0, $urandom);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_VECTOR, default 32'hBFC00000, meaning the fetch address expected first after reset (checked only by the bench; the PC register owns the value).
REQ-002 The block SHALL have parameter HALT_ADDR, default 32'h00000000, meaning the PC value at which fetching stops.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port pc, input, 32, the current PC register output.
REQ-006 The block SHALL have port pc_en, output, 1, the clk_enable for the PC register.
REQ-007 The block SHALL have port address, output, 32, the Avalon-MM read address.
REQ-008 The block SHALL have port read, output, 1, the Avalon-MM read strobe.
REQ-009 The block SHALL have port byteenable, output, 4, the Avalon-MM byte lanes.
REQ-010 The block SHALL have port waitrequest, input, 1, the Avalon-MM slave stall.
REQ-011 The block SHALL have port readdata, input, 32, the Avalon-MM read data.
REQ-012 The block SHALL have port stall, input, 1, meaning the datapath is busy and the PC must not advance.
REQ-013 The block SHALL have port instr, output, 32, the latched instruction word.
REQ-014 The block SHALL have port instr_valid, output, 1, meaning instr holds the instruction at pc.
REQ-015 The block SHALL have port active, output, 1, meaning the CPU is running (not halted).

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, EXEC and HALT, all registered.
REQ-017 IDLE SHALL go to FETCH on the first clk edge after reset deasserts, with all outputs inactive during IDLE.
REQ-018 In FETCH, if pc == HALT_ADDR, then read = 0 and the next state SHALL be HALT.
REQ-019 Otherwise in FETCH: read = 1, address = pc, byteenable = 4'hF, pc_en = 0.
REQ-020 While in FETCH, if waitrequest = 1 the block SHALL stay in FETCH with address, read and byteenable held stable.
REQ-021 While in FETCH, if waitrequest = 0 the block SHALL capture readdata into instr on that edge and go to EXEC.
REQ-022 In EXEC: read = 0, instr_valid = 1, and instr SHALL be held.
REQ-023 In EXEC with stall = 1, the block SHALL stay in EXEC with pc_en = 0.
REQ-024 In EXEC with stall = 0, pc_en SHALL be 1 for exactly that cycle and the next state SHALL be FETCH.
REQ-025 pc_en SHALL never be 1 outside EXEC, so the PC advances exactly once per accepted instruction.
REQ-026 Minimum throughput SHALL be 2 cycles per instruction (waitrequest = 0 and stall = 0): one FETCH cycle and one EXEC cycle.
REQ-027 With waitrequest held 1 for N cycles, the fetch SHALL take N+1 FETCH cycles with no timeout.
REQ-028 In HALT: active = 0, read = 0, pc_en = 0, instr_valid = 0; HALT SHALL be left only by reset.
REQ-029 active SHALL be 1 in FETCH and EXEC, and 0 in IDLE and HALT.
REQ-030 byteenable SHALL be 4'h0 whenever read = 0.
REQ-031 address SHALL equal pc while read = 1 and SHALL be 32'h0 otherwise.
REQ-032 If stall and waitrequest are asserted together in FETCH, waitrequest SHALL govern; stall SHALL be ignored outside EXEC.
REQ-033 The HALT_ADDR comparison SHALL be an exact 32-bit equality.

Reset
REQ-034 reset = 0 SHALL immediately (asynchronously) force state IDLE, read = 0, pc_en = 0, instr = 32'h0, instr_valid = 0, active = 0, address = 32'h0, byteenable = 4'h0.
REQ-035 Reset asserted mid-fetch (read = 1, waitrequest = 1) SHALL drop read in the same cycle, and a later readdata SHALL NOT be captured.
REQ-036 After reset release the block SHALL restart from IDLE regardless of its prior state, including HALT.

Verification
REQ-037 Reset release, pc = 32'hBFC00000, waitrequest = 0, stall = 0 -> read = 1 at address BFC00000 in the 2nd cycle; pc_en pulses every 2nd cycle; 100 instructions give exactly 100 pc_en pulses.
REQ-038 waitrequest held 1 for 3 cycles, readdata = 32'h2402000A -> address stable for 4 FETCH cycles; instr = 2402000A with instr_valid = 1 in the following cycle.
REQ-039 stall = 1 for 5 cycles in EXEC -> pc_en = 0 and instr held for 5 cycles; pc_en = 1 on the 6th cycle.
REQ-040 pc driven to 32'h00000000 -> no read issued; active falls to 0 one cycle later and stays 0 for 50 further cycles.
REQ-041 Reset pulsed low during FETCH with waitrequest = 1 -> read = 0 within the same cycle, instr = 0; normal fetch resumes after release.
REQ-042 Every cycle (assertion): read = 1 implies byteenable = 4'hF, pc_en = 1 implies instr_valid = 1, and read and pc_en are never both 1.
